// File: rtl/linebuffer_scanout.sv
// linebuffer_scanout: display-side reader for the ping-pong line buffer.
// Flips buffer roles on each line_start, streams one line of pixels through a
// 2-entry skid buffer under valid/ready, and clears consumed tiles behind itself.
// Optional feature macro: SCANOUT_CLEAR_EN (clear-behind tile writes).
module linebuffer_scanout #(
  parameter int unsigned LINE_PIXELS = 640,
  parameter logic [15:0] BG_COLOR    = 16'h0000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         line_start,
  output logic         switch,
  output logic [9:0]   addr_pixel_disp,
  input  logic [15:0]  q_pixel_disp,
  output logic         wren_pixel_disp,
  output logic [15:0]  data_pixel_disp,
  output logic [5:0]   addr_tile_disp,
  output logic [255:0] data_tile_disp,
  output logic         wren_tile_disp,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic [15:0]  pix_data,
  output logic         pix_last,
  output logic         busy,
  output logic         late
);

  localparam int unsigned AW = 10;
  localparam int unsigned PW = 16;
  localparam logic [AW-1:0] LAST_ADDR = AW'(LINE_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, SWAP, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic            switch_q, switch_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_pend_q, rd_pend_d;
  logic [AW-1:0]   pend_addr_q, pend_addr_d;
  logic            v0_q, v0_d, v1_q, v1_d;
  logic [PW-1:0]   d0_q, d0_d, d1_q, d1_d;
  logic            l0_q, l0_d, l1_q, l1_d;
  logic            busy_q, busy_d;
  logic            late_q, late_d;

  logic            pop;
  logic            push;
  logic            ret_last;
  logic [1:0]      credit;
  logic            issue_ok;
  logic            drain_done;

  assign pop      = v0_q & pix_ready;
  assign push     = rd_pend_q;
  assign ret_last = (pend_addr_q == LAST_ADDR);
  // Skid occupancy after this cycle's pop plus the read still in flight.
  assign credit   = 2'(v0_q) + 2'(v1_q) + 2'(rd_pend_q) - 2'(pop);
  assign issue_ok = (credit < 2'd2);
  // No read in flight means the last tile clear was already registered on its return.
  assign drain_done = !rd_pend_q && !v1_q && (!v0_q || pop);

  // Next-state, read issue and skid buffer update.
  always_comb begin
    state_d     = state_q;
    switch_d    = switch_q;
    addr_d      = addr_q;
    rd_pend_d   = 1'b0;
    pend_addr_d = pend_addr_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    l0_d        = l0_q;
    l1_d        = l1_q;
    late_d      = 1'b0;

    unique case ({push, pop})
      2'b11: begin
        if (v1_q) begin
          d0_d = d1_q;
          l0_d = l1_q;
          d1_d = q_pixel_disp;
          l1_d = ret_last;
        end else begin
          d0_d = q_pixel_disp;
          l0_d = ret_last;
        end
      end
      2'b01: begin
        d0_d = d1_q;
        l0_d = l1_q;
        v0_d = v1_q;
        v1_d = 1'b0;
      end
      2'b10: begin
        if (!v0_q) begin
          d0_d = q_pixel_disp;
          l0_d = ret_last;
          v0_d = 1'b1;
        end else begin
          d1_d = q_pixel_disp;
          l1_d = ret_last;
          v1_d = 1'b1;
        end
      end
      default: ;
    endcase

    unique case (state_q)
      IDLE:   ;
      SWAP:   state_d = STREAM;
      STREAM: begin
        if (issue_ok) begin
          rd_pend_d   = 1'b1;
          pend_addr_d = addr_q;
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      DRAIN:  if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A line start always restarts; mid-line it aborts and drops returns.
    if (line_start) begin
      switch_d  = ~switch_q;
      addr_d    = '0;
      rd_pend_d = 1'b0;
      v0_d      = 1'b0;
      v1_d      = 1'b0;
      state_d   = SWAP;
      late_d    = (state_q != IDLE) && !((state_q == DRAIN) && drain_done);
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      switch_q    <= 1'b0;
      addr_q      <= '0;
      rd_pend_q   <= 1'b0;
      pend_addr_q <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
      l0_q        <= 1'b0;
      l1_q        <= 1'b0;
      busy_q      <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      switch_q    <= switch_d;
      addr_q      <= addr_d;
      rd_pend_q   <= rd_pend_d;
      pend_addr_q <= pend_addr_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      l0_q        <= l0_d;
      l1_q        <= l1_d;
      busy_q      <= busy_d;
      late_q      <= late_d;
    end
  end

`ifdef SCANOUT_CLEAR_EN
  logic       tile_wren_q;
  logic [5:0] tile_addr_q;
  logic       tile_done;

  assign tile_done = rd_pend_q && !line_start && (pend_addr_q[3:0] == 4'hF);

  // Clear a tile the cycle after its sixteenth pixel returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tile_wren_q <= 1'b0;
      tile_addr_q <= '0;
    end else begin
      tile_wren_q <= tile_done;
      if (tile_done) tile_addr_q <= pend_addr_q[AW-1:4];
    end
  end

  assign wren_tile_disp = tile_wren_q;
  assign addr_tile_disp = tile_addr_q;
`else
  assign wren_tile_disp = 1'b0;
  assign addr_tile_disp = '0;
`endif

  assign switch          = switch_q;
  assign addr_pixel_disp = addr_q;
  assign wren_pixel_disp = 1'b0;
  assign data_pixel_disp = BG_COLOR;
  assign data_tile_disp  = {16{BG_COLOR}};
  assign pix_valid       = v0_q;
  assign pix_data        = d0_q;
  assign pix_last        = l0_q;
  assign busy            = busy_q;
  assign late            = late_q;

endmodule

// File: tb/tb_linebuffer_scanout.sv
// Testbench for linebuffer_scanout: line-buffer RAM model, line-level pixel
// scoreboard checked every cycle, plus directed timing checks.
module tb_linebuffer_scanout;

  localparam int          NPIX = 640;
  localparam logic [15:0] BG   = 16'h0000;
`ifdef SCANOUT_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         line_start;
  logic         switch;
  logic [9:0]   addr_pixel_disp;
  logic [15:0]  q_pixel_disp;
  logic         wren_pixel_disp;
  logic [15:0]  data_pixel_disp;
  logic [5:0]   addr_tile_disp;
  logic [255:0] data_tile_disp;
  logic         wren_tile_disp;
  logic         pix_valid;
  logic         pix_ready;
  logic [15:0]  pix_data;
  logic         pix_last;
  logic         busy;
  logic         late;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  linebuffer_scanout #(.LINE_PIXELS(NPIX), .BG_COLOR(BG)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .switch(switch),
    .addr_pixel_disp(addr_pixel_disp), .q_pixel_disp(q_pixel_disp),
    .wren_pixel_disp(wren_pixel_disp), .data_pixel_disp(data_pixel_disp),
    .addr_tile_disp(addr_tile_disp), .data_tile_disp(data_tile_disp),
    .wren_tile_disp(wren_tile_disp), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last), .busy(busy), .late(late)
  );

  // Ping-pong line buffer display side: registered select, 1-cycle read latency.
  logic [15:0] mem [2][1024];
  logic        sel;
  always @(posedge clk) begin
    sel <= switch;
    q_pixel_disp <= mem[sel][addr_pixel_disp];
    if (wren_tile_disp)
      for (int j = 0; j < 16; j++)
        mem[sel][{addr_tile_disp, 4'(j)}] <= data_tile_disp[16*j +: 16];
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Line contents: bank 1 holds the address, bank 0 holds 0x4000+address,
  // and a fully read line is blank afterwards when clearing is built in.
  bit cleared [2];
  function automatic logic [15:0] exp_pix(input int b, input int i);
    if (cleared[b]) return BG;
    return (b == 1) ? 16'(i) : 16'(16'h4000 + i);
  endfunction

  // Scoreboard state.
  int          m_sw, m_idx, m_tile, k;
  bit          m_active;
  int          first_seen [1024];
  logic        p_valid, p_ready, p_ls, p_last;
  logic [15:0] p_data;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_sw = 0; m_idx = 0; m_tile = 0; m_active = 0;
      p_valid = 0; p_ready = 0; p_ls = 0;
    end else begin
      chk("switch", switch, m_sw);
      if (p_valid && !p_ready && !p_ls) begin
        chk("hold_valid", pix_valid, 1);
        chk("hold_data", pix_data, p_data);
        chk("hold_last", pix_last, p_last);
      end
`ifdef SCANOUT_CLEAR_EN
      if (wren_tile_disp) begin
        chk("tile_addr", addr_tile_disp, m_tile);
        chk("tile_data", data_tile_disp, {16{BG}});
        k = 16 * m_tile + 15;
        chk("tile_after_read", (k < 1024) && first_seen[k] >= 0 && first_seen[k] <= cyc - 2, 1);
        m_tile++;
      end
`else
      chk("tile_wren_off", wren_tile_disp, 0);
      chk("tile_addr_off", addr_tile_disp, 0);
`endif
      if (pix_valid && pix_ready) begin
        chk("xfer_in_line", m_active && m_idx < NPIX, 1);
        chk("pix_data", pix_data, exp_pix(m_sw, m_idx));
        chk("pix_last", pix_last, m_idx == NPIX - 1);
        if (m_idx == NPIX - 1 && CLR) cleared[m_sw] = 1'b1;
        m_idx++;
      end
      if (m_active && first_seen[addr_pixel_disp] < 0) first_seen[addr_pixel_disp] = cyc;
      if (line_start) begin
        m_sw = 1 - m_sw; m_active = 1; m_idx = 0; m_tile = 0;
        for (int i = 0; i < 1024; i++) first_seen[i] = -1;
      end
      p_valid = pix_valid; p_ready = pix_ready; p_ls = line_start;
      p_data = pix_data; p_last = pix_last;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    while (busy && n < budget) begin
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
    pix_ready = 1'b1;
    tick();
  endtask

  task automatic start_line(output int t);
    t = cyc;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t0, t2, te;

  initial begin
    reset_n = 1'b0; line_start = 1'b0; pix_ready = 1'b1; sel = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem[0][i] = 16'(16'h4000 + i);
      mem[1][i] = 16'(i);
    end
    repeat (3) tick();
    chk("rst_switch", switch, 0);
    chk("rst_wren_tile", wren_tile_disp, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_last", pix_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_late", late, 0);
    chk("rst_addr_pix", addr_pixel_disp, 0);
    chk("rst_addr_tile", addr_tile_disp, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("wren_pixel", wren_pixel_disp, 0);
    chk("data_pixel", data_pixel_disp, BG);
    reset_n = 1'b1;
    repeat (2) tick();

    // Line A: full rate on bank 1.
    start_line(t0);
    chk("A_switch", switch, 1);
    chk("A_busy", busy, 1);
    chk("A_late", late, 0);
    goto(t0 + 3);  chk("A_valid_t3", pix_valid, 0);
    goto(t0 + 4);  chk("A_valid_t4", pix_valid, 1); chk("A_first", pix_data, 16'd0);
`ifdef SCANOUT_CLEAR_EN
    goto(t0 + 19); chk("A_tile0_wren", wren_tile_disp, 1); chk("A_tile0_addr", addr_tile_disp, 0);
`endif
    goto(t0 + 642); chk("A_last_early", pix_last, 0);
    goto(t0 + 643); chk("A_last", pix_last, 1); chk("A_last_data", pix_data, 16'd639);
`ifdef SCANOUT_CLEAR_EN
    chk("A_tile39_wren", wren_tile_disp, 1); chk("A_tile39_addr", addr_tile_disp, 39);
`endif
    goto(t0 + 646); chk("A_busy_end", busy, 0); chk("A_count", m_idx, NPIX);
`ifdef SCANOUT_CLEAR_EN
    chk("A_tiles", m_tile, 40);
`endif

    // Line B: random backpressure on bank 0.
    start_line(t0);
    wait_idle(5000, 1'b1);
    chk("B_count", m_idx, NPIX);

    // Line C: bank 1 re-read, aborted at T+100; restart D on bank 0.
    start_line(t0);
    goto(t0 + 100);
    start_line(t2);
    chk("C_late", late, 1);
    chk("C_switch_back", switch, 0);
    chk("C_flush", pix_valid, 0);
    tick();
    chk("C_late_pulse", late, 0);
    goto(t2 + 3); chk("D_valid_t3", pix_valid, 0);
    goto(t2 + 4); chk("D_valid_t4", pix_valid, 1); chk("D_first", pix_data, exp_pix(0, 0));

    // Line E starts in the DRAIN exit cycle of D: no late pulse.
    goto(t2 + 643);
    chk("D_count_before_last", m_idx, NPIX - 1);
    start_line(te);
    chk("E_late", late, 0);
    chk("E_switch", switch, 1);
    chk("E_busy", busy, 1);
    goto(te + 4); chk("E_valid_t4", pix_valid, 1); chk("E_first", pix_data, exp_pix(1, 0));

    // Reset mid-stream, then a line behaves as after power-up.
    goto(te + 50);
    reset_n = 1'b0;
    #1;
    chk("R_valid", pix_valid, 0);
    chk("R_wren", wren_tile_disp, 0);
    chk("R_switch", switch, 0);
    chk("R_busy", busy, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    start_line(t0);
    chk("F_switch", switch, 1);
    chk("F_late", late, 0);
    goto(t0 + 3);   chk("F_valid_t3", pix_valid, 0);
    goto(t0 + 4);   chk("F_valid_t4", pix_valid, 1); chk("F_first", pix_data, exp_pix(1, 0));
    goto(t0 + 643); chk("F_last", pix_last, 1);
    wait_idle(50, 1'b0);
    chk("F_count", m_idx, NPIX);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
